// File: rtl/membank_pipe_if.sv
// Request/response bus of the lane-strobed memory bank.
// The requester drives the master side; the bank implements the slave side.
interface membank_pipe_if #(
    parameter int unsigned noLanes   = 32,
    parameter int unsigned laneSize  = 8,
    parameter int unsigned addrWidth = 22
);
    logic                          opreq;
    logic                          oprdy;
    logic                          rwbar_in;
    logic [addrWidth-1:0]          wordAddr_in;
    logic [noLanes*laneSize-1:0]   wdata_in;
    logic [noLanes-1:0]            lanes_in;
    logic                          ack;
    logic [noLanes*laneSize-1:0]   rdata;
    logic                          ack_wr;
    logic                          ack_err;
    logic                          rsp_rdy;

    modport master (
        output opreq, rwbar_in, wordAddr_in, wdata_in, lanes_in, rsp_rdy,
        input  oprdy, ack, rdata, ack_wr, ack_err
    );

    modport slave (
        input  opreq, rwbar_in, wordAddr_in, wdata_in, lanes_in, rsp_rdy,
        output oprdy, ack, rdata, ack_wr, ack_err
    );
endinterface

// File: rtl/membank_pipe.sv
// Lane-strobed word memory with fixed read latency and a credit-limited
// response FIFO; every accepted op, read or write, returns exactly one ack.
module membank_pipe #(
    parameter int unsigned noLanes   = 32,
    parameter int unsigned laneSize  = 8,
    parameter int unsigned memsize   = 32,
    parameter int unsigned addrWidth = 22,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic           clk,
    input  logic           reset,
    membank_pipe_if.slave  bus
);
    localparam int unsigned DW     = noLanes * laneSize;
    localparam int unsigned MW     = (memsize > 1) ? $clog2(memsize) : 1;
    localparam int unsigned PW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW     = $clog2(RSP_DEPTH + 1);
    localparam int          STAGES = int'(LATENCY) - 1;

    typedef struct packed {
        logic          wr;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] mem [memsize];

    logic          oprdy_q;
    logic          ack_q;
    rsp_t          head_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0] fifo_cnt_q, credit_q, fifo_cnt_n, credit_n;
    rsp_t          fifo_q [RSP_DEPTH];
    rsp_t          head_n;

    logic          accept_c, pop_c, push_c, in_range_c;
    logic [MW-1:0] mem_idx_c;
    rsp_t          stage0_r, fifo_in_r;

    assign in_range_c = (bus.wordAddr_in < addrWidth'(memsize));
    assign mem_idx_c  = bus.wordAddr_in[MW-1:0];
    // Reset gates acceptance so nothing commits while the bank is held in reset.
    assign accept_c   = bus.opreq && oprdy_q && reset;
    assign pop_c      = ack_q && bus.rsp_rdy;

    // Commit: strobed lanes of in-range writes land at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept_c && !bus.rwbar_in && in_range_c) begin
            for (int i = 0; i < int'(noLanes); i++) begin
                if (bus.lanes_in[i])
                    mem[mem_idx_c][i*laneSize +: laneSize] <= bus.wdata_in[i*laneSize +: laneSize];
            end
        end
    end

    always_comb begin
        stage0_r     = '0;
        stage0_r.wr  = ~bus.rwbar_in;
        stage0_r.err = ~in_range_c;
        if (bus.rwbar_in && in_range_c)
            stage0_r.data = mem[mem_idx_c];
    end

    // Tags ride LATENCY-1 register stages before entering the FIFO.
    if (LATENCY == 1) begin : g_direct
        assign push_c    = accept_c;
        assign fifo_in_r = stage0_r;
    end else begin : g_pipe
        logic [STAGES-1:0] pv_q;
        rsp_t              pd_q [STAGES];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= accept_c;
                for (int i = 1; i < STAGES; i++)
                    pv_q[i] <= pv_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            pd_q[0] <= stage0_r;
            for (int i = 1; i < STAGES; i++)
                pd_q[i] <= pd_q[i-1];
        end

        assign push_c    = pv_q[STAGES-1];
        assign fifo_in_r = pd_q[STAGES-1];
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next FIFO/credit state; head is pre-computed so outputs come straight from flops.
    always_comb begin
        rd_ptr_n   = pop_c  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_n   = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        fifo_cnt_n = fifo_cnt_q + CW'(push_c) - CW'(pop_c);
        credit_n   = credit_q + CW'(accept_c) - CW'(pop_c);
        head_n     = '0;
        if (fifo_cnt_n != '0)
            head_n = (push_c && (wr_ptr_q == rd_ptr_n)) ? fifo_in_r : fifo_q[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (push_c)
            fifo_q[wr_ptr_q] <= fifo_in_r;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            credit_q   <= '0;
            oprdy_q    <= 1'b1;
            ack_q      <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_n;
            rd_ptr_q   <= rd_ptr_n;
            fifo_cnt_q <= fifo_cnt_n;
            credit_q   <= credit_n;
            oprdy_q    <= (credit_n < CW'(RSP_DEPTH));
            ack_q      <= (fifo_cnt_n != '0);
            head_q     <= head_n;
        end
    end

    assign bus.oprdy   = oprdy_q;
    assign bus.ack     = ack_q;
    assign bus.rdata   = head_q.data;
    assign bus.ack_wr  = head_q.wr;
    assign bus.ack_err = head_q.err;
endmodule

// File: tb/tb_membank_pipe.sv
// Drives four latency/depth configurations of membank_pipe with one shared
// stimulus stream; each has an outstanding-op queue model with ready times.
module tb_membank_pipe;
    localparam int unsigned NL   = 32;
    localparam int unsigned DW   = NL * 8;
    localparam int unsigned AW   = 22;
    localparam int unsigned MS   = 32;
    localparam int unsigned NCFG = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          opreq = 1'b0;
    logic          rwbar = 1'b1;
    logic          rsp_rdy = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [NL-1:0] lanes = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            ready;
        logic          wr;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
        localparam int unsigned DEP = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 3 : 1;

        membank_pipe_if #(.noLanes(NL), .laneSize(8), .addrWidth(AW)) bus();

        membank_pipe #(
            .noLanes(NL), .laneSize(8), .memsize(MS), .addrWidth(AW),
            .LATENCY(LAT), .RSP_DEPTH(DEP)
        ) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus)
        );

        assign bus.opreq       = opreq;
        assign bus.rwbar_in    = rwbar;
        assign bus.wordAddr_in = addr;
        assign bus.wdata_in    = wdata;
        assign bus.lanes_in    = lanes;
        assign bus.rsp_rdy     = rsp_rdy;

        exp_t          q[$];
        logic [DW-1:0] ref_mem [MS];
        int            cyc = 0;
        int            acc_cnt = 0;

        // Model: an op is outstanding from acceptance until popped; it is visible
        // at the head once LAT edges have passed, and credits = outstanding ops.
        always @(posedge clk) begin
            logic rdy_now, ack_now;
            exp_t e;
            rdy_now = (q.size() < int'(DEP));
            ack_now = (q.size() > 0) && (q[0].ready <= cyc);
            if (!reset) begin
                q.delete();
            end else begin
                if (ack_now && rsp_rdy)
                    void'(q.pop_front());
                if (opreq && rdy_now) begin
                    e.ready = cyc + int'(LAT);
                    e.err   = (addr >= AW'(MS));
                    e.wr    = !rwbar;
                    e.data  = (!e.wr && !e.err) ? ref_mem[addr[4:0]] : '0;
                    q.push_back(e);
                    acc_cnt <= acc_cnt + 1;
                    if (e.wr && !e.err) begin
                        for (int i = 0; i < int'(NL); i++)
                            if (lanes[i]) ref_mem[addr[4:0]][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end
            cyc <= cyc + 1;
        end

        always @(negedge clk) begin
            logic ack_exp;
            ack_exp = (q.size() > 0) && (q[0].ready <= cyc);
            if (!reset) begin
                check($sformatf("c%0d_rst_ack", g), bus.ack, 1'b0);
                check($sformatf("c%0d_rst_rdata", g), bus.rdata, '0);
                check($sformatf("c%0d_rst_wr", g), bus.ack_wr, 1'b0);
                check($sformatf("c%0d_rst_err", g), bus.ack_err, 1'b0);
            end else begin
                check($sformatf("c%0d_oprdy", g), bus.oprdy, (q.size() < int'(DEP)));
                check($sformatf("c%0d_ack", g), bus.ack, ack_exp);
                if (ack_exp) begin
                    check($sformatf("c%0d_rdata", g), bus.rdata, q[0].data);
                    check($sformatf("c%0d_ack_wr", g), bus.ack_wr, q[0].wr);
                    check($sformatf("c%0d_ack_err", g), bus.ack_err, q[0].err);
                end
            end
        end
    end

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < int'(DW / 32); i++)
            w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // Presents one op for exactly one edge; configs that are not ready just miss it.
    task automatic op(input logic rd, input int a, input logic [DW-1:0] d, input logic [NL-1:0] ln);
        @(negedge clk);
        opreq = 1'b1;
        rwbar = rd;
        addr  = AW'(a);
        wdata = d;
        lanes = ln;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            opreq = 1'b0;
        end
    endtask

    task automatic get_rd(output logic [DW-1:0] d, output logic err);
        int n = 0;
        do begin
            @(negedge clk);
            opreq = 1'b0;
            n++;
        end while (!(cfg[0].bus.ack && !cfg[0].bus.ack_wr) && n < 20);
        check("rd_rsp_seen", cfg[0].bus.ack && !cfg[0].bus.ack_wr, 1'b1);
        d   = cfg[0].bus.rdata;
        err = cfg[0].bus.ack_err;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          err;
        int            acks, first, last, acc0;

        repeat (3) @(negedge clk);
        #1 reset = 1'b1;

        for (int a = 0; a < int'(MS); a++) begin
            op(1'b0, a, rnd_word(), '1);
            idle(5);
        end

        // Single-cycle legacy timing on the LATENCY=1 instance.
        op(1'b0, 5, {32{8'h11}}, '1);
        op(1'b1, 5, '0, '0);
        @(negedge clk);
        opreq = 1'b0;
        check("lat1_ack", cfg[0].bus.ack, 1'b1);
        check("lat1_ack_wr", cfg[0].bus.ack_wr, 1'b0);
        check("lat1_rdata", cfg[0].bus.rdata, {32{8'h11}});
        idle(6);

        op(1'b0, 7, {32{8'hAA}}, '1);
        idle(5);
        op(1'b0, 7, {32{8'h55}}, 32'h0000_000F);
        idle(5);
        op(1'b1, 7, '0, '0);
        get_rd(d, err);
        check("lanes_rdata", d, {{28{8'hAA}}, {4{8'h55}}});
        idle(6);

        op(1'b0, 40, rnd_word(), '1);
        idle(5);
        op(1'b1, 8, '0, '0);
        idle(5);
        op(1'b1, 40, '0, '0);
        get_rd(d, err);
        check("oor_err", err, 1'b1);
        check("oor_rdata", d, '0);
        idle(8);

        // 16 back-to-back reads; LATENCY=3/RSP_DEPTH=4 instance must never stall.
        acks = 0; first = -1; last = -1;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            if (cfg[1].bus.ack) begin
                acks++;
                if (first < 0) first = t;
                last = t;
            end
            if (t < 16) check("tput_oprdy", cfg[1].bus.oprdy, 1'b1);
            opreq = (t < 16);
            rwbar = 1'b1;
            addr  = AW'(t);
        end
        opreq = 1'b0;
        check("tput_acks", 32'(acks), 32'd16);
        check("tput_first", 32'(first), 32'd3);
        check("tput_last", 32'(last), 32'd18);
        idle(8);

        // Backpressure with opreq held: LATENCY=2/RSP_DEPTH=3 takes exactly 3.
        @(negedge clk);
        rsp_rdy = 1'b0;
        acc0 = cfg[2].acc_cnt;
        for (int t = 0; t < 6; t++) begin
            op(1'b1, int'($urandom_range(0, 31)), '0, '0);
        end
        @(negedge clk);
        opreq = 1'b0;
        check("bp_accepts", 32'(cfg[2].acc_cnt - acc0), 32'd3);
        check("bp_oprdy", cfg[2].bus.oprdy, 1'b0);
        check("bp_ack", cfg[2].bus.ack, 1'b1);
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("bp_oprdy_back", cfg[2].bus.oprdy, 1'b1);
        idle(10);

        // Reset with reads in flight discards them but keeps committed memory.
        op(1'b1, 1, '0, '0);
        op(1'b1, 2, '0, '0);
        @(negedge clk);
        opreq = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        acks = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (t == 0)
                check("rst_oprdy", {cfg[0].bus.oprdy, cfg[1].bus.oprdy, cfg[2].bus.oprdy, cfg[3].bus.oprdy}, 4'hF);
            acks += int'(cfg[0].bus.ack) + int'(cfg[1].bus.ack) + int'(cfg[2].bus.ack) + int'(cfg[3].bus.ack);
        end
        check("rst_no_ack", 32'(acks), 32'd0);
        op(1'b1, 5, '0, '0);
        get_rd(d, err);
        check("rst_mem_kept", d, {32{8'h11}});
        idle(6);

        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            opreq   = ($urandom_range(0, 3) != 0);
            rwbar   = $urandom_range(0, 1) != 0;
            addr    = AW'($urandom_range(0, 47));
            wdata   = rnd_word();
            lanes   = $urandom();
            rsp_rdy = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        opreq   = 1'b0;
        rsp_rdy = 1'b1;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/membank_pipe.md
Name: membank_pipe

Overview:
Parametrised successor to the single-cycle BRAM lane bank: a wide word memory of noLanes x laneSize bits with per-lane write strobes.
- Adds a configurable read latency of 1..4 cycles.
- Adds a credit-limited response FIFO, so the consumer can apply backpressure via rsp_rdy.
- Returns one ack per accepted operation, reads and writes alike, with write/error tags.
- Flags out-of-range addresses.

Sits between the Kiwi datapath request port and on-chip BRAM.

Parameters:
noLanes, 32, number of byte lanes per word
laneSize, 8, bits per lane
memsize, 32, words stored (address range 0..memsize-1)
addrWidth, 22, width of wordAddr_in
LATENCY, 2, acceptance-to-ack latency in cycles (1..4)
RSP_DEPTH, 3, response credits; must be >= LATENCY+1 for full throughput, >= 1 legal

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
opreq  in  1  new operation request
oprdy  out  1  bank can accept; op accepted at a rising edge where opreq && oprdy
rwbar_in  in  1  1 = read, 0 = write
wordAddr_in  in  addrWidth  word address
wdata_in  in  noLanes*laneSize  write data
lanes_in  in  noLanes  per-lane write strobes (ignored for reads)
ack  out  1  response valid (head of response FIFO)
rdata  out  noLanes*laneSize  read data of head response; 0 for writes and errors
ack_wr  out  1  head response belongs to a write
ack_err  out  1  head response had address >= memsize
rsp_rdy  in  1  consumer takes head response at an edge where ack && rsp_rdy

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears the pipeline valid bits, FIFO pointers and credit counter.
  - ack=0, ack_wr=0, ack_err=0, rdata=0, oprdy=1 once reset is released.
  - Memory contents are not reset.
  - Reset mid-operation discards all in-flight and queued responses; writes already committed stay in memory.
- Commit:
  - An op accepted at edge k commits at edge k.
  - A write updates lane i iff lanes_in[i]=1 and the address is in range.
  - A read samples the array at edge k. A read accepted at k+1 sees a write committed at k.
  - Ops execute strictly in acceptance order; there are no hazards.
- Response pipeline:
  - Accepted-op tags (valid, wr, err, data) travel LATENCY-1 register stages, then enter the response FIFO at edge k+LATENCY-1.
  - With an empty FIFO, ack is asserted in the cycle after edge k+LATENCY-1.
  - LATENCY=1 reproduces the legacy single-cycle timing.
- Response FIFO:
  - Depth RSP_DEPTH; its head drives ack, rdata, ack_wr and ack_err.
  - Pop happens when ack && rsp_rdy.
  - Responses emerge in order, one per accepted op, never duplicated or dropped.
  - rdata, ack_wr and ack_err hold stable while ack=1 and rsp_rdy=0.
- Credits:
  - count = ops in the pipeline + entries in the FIFO.
  - oprdy = (count < RSP_DEPTH), with no combinational path from rsp_rdy or opreq.
  - count increments on accept and decrements on pop; simultaneous accept+pop leaves it unchanged.
  - The FIFO therefore never overflows, and its wrap-around pointers are modulo RSP_DEPTH.
- Full throughput: with rsp_rdy held 1 and RSP_DEPTH >= LATENCY+1, oprdy stays 1 and one op per cycle is sustained.
- Out of range (address >= memsize):
  - Writes are suppressed.
  - Reads return rdata=0.
  - The response is tagged ack_err=1; ack still occurs.
- Write responses carry ack_wr=1 and rdata=0.
- Inputs are don't-care when opreq=0 or oprdy=0.

Test Plan:
- LATENCY=1: write addr 5 data 0x11..11 with all lanes, then read 5 next cycle. Required: read ack in the cycle after its accept edge, rdata=0x11..11, ack_wr=0.
- LATENCY=3, RSP_DEPTH=4, rsp_rdy=1: 16 back-to-back reads of addr 0..15. Required: oprdy never drops, 16 consecutive acks starting 3 cycles after the first accept, in address order.
- LATENCY=2, RSP_DEPTH=3, rsp_rdy=0, opreq held 1. Required: exactly 3 accepts, then oprdy=0. Head stays stable. Raising rsp_rdy drains 3 responses in order, and oprdy returns to 1 the cycle after the first pop.
- Prefill addr 7 with 0xAA in each lane, then write 0x55 in each lane with lanes=0x0000000F, then read. Required: rdata low 4 bytes 0x55, upper 28 bytes 0xAA.
- memsize=32:
  - Write addr 40: required ack with ack_err=1, ack_wr=1, and addr 8 left unchanged.
  - Read addr 40: required ack_err=1, rdata=0.
- Issue 2 reads, assert reset low for 1 cycle before any ack. Required:
  - no ack afterwards;
  - oprdy=1 after release;
  - memory written before reset still reads back correctly.
